cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Shares the single memory port between the core's instruction bus (ireq/iresp) and data bus (dreq/dresp).
- Sits between MyCore and the memory/cache side.
- One outstanding transaction at a time. The requester that wins arbitration is latched. dbus has priority, and a starvation counter guarantees ibus progress.
- Converts ibus requests into full-width data-bus-format requests: size 4 bytes, strobe 0.

Parameters:
- STARVE_LIMIT, 4: number of consecutive lost arbitrations after which a pending ibus request wins over dbus. Range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ireq  in  ibus_req_t  fetch request {valid, addr}
- iresp  out  ibus_resp_t  fetch response {addr_ok, data_ok, data}
- dreq  in  dbus_req_t  data request {valid, addr, size, strobe, data}
- dresp  out  dbus_resp_t  data response {addr_ok, data_ok, data}
- oreq  out  dbus_req_t  request to the memory side
- oresp  in  dbus_resp_t  response from the memory side

Behaviour:
- State machine states: IDLE, ADDR, DATA. Registers: state, sel (0=ibus, 1=dbus), req_q (dbus_req_t), starve (CNT_W bits).
- Reset: on any clk edge with resetn=0:
  - state=IDLE, req_q='0, sel=0, starve=0.
  - All outputs '0 in the same cycle, because outputs are decoded from state.
  - This also applies mid-transaction; any in-flight oresp is then ignored.
- IDLE:
  - oreq.valid=0; iresp and dresp are '0.
  - If neither valid is set, stay in IDLE.
  - Otherwise pick the winner, latch it into req_q, set sel, and go to ADDR next cycle. Minimum grant latency is 1 cycle from valid to oreq.valid.
- Winner selection:
  - dreq.valid only: dbus wins.
  - ireq.valid only: ibus wins.
  - Both valid: ibus wins if starve >= STARVE_LIMIT, else dbus wins.
- Starvation counter, updated at each IDLE decision:
  - Both valid and dbus wins: starve <= starve+1, saturating at STARVE_LIMIT.
  - ibus wins, or ireq.valid=0: starve <= 0.
- ibus latch mapping: req_q = {valid=1, addr=ireq.addr, size=MSIZE4, strobe=4'b0, data=0}.
- ADDR:
  - oreq = req_q, held stable until oresp.addr_ok.
  - oresp.addr_ok is routed combinationally to the selected requester's addr_ok in the same cycle. The other requester sees 0.
  - addr_ok=1 and data_ok=0: go to DATA.
  - addr_ok=1 and data_ok=1 in the same cycle: forward both plus data, then go to IDLE.
  - addr_ok=0: stay in ADDR.
- DATA:
  - oreq.valid=0.
  - oresp.data_ok and oresp.data are routed to the selected requester only. The other requester's resp is '0.
  - On data_ok, go to IDLE; otherwise stay.
- Non-selected requester: its resp is always '0. Its valid may rise, fall, or hold at any time without affecting the transaction in flight.
- Back-to-back: after data_ok the next grant is decided in the following IDLE cycle. Turnaround is 1 idle cycle between transactions.
- The unused fields of oresp are ignored. oresp.data on a dbus write is forwarded unmodified.

Decomposition:
- Shared package (common.svh):
  - Existing ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, and the MSIZE4 constant.
  - New enum arb_state_t {IDLE, ADDR, DATA}.
- No sub-module. Selection, counter and FSM are one module, about 150 lines.

Test Plan:
- Single fetch:
  - Stimulus: ireq.valid=1, addr=32'hBFC0_0000; memory gives addr_ok 2 cycles after oreq.valid, then data_ok with data=32'h2408_0001 after 3 more cycles.
  - Required response: oreq appears 1 cycle after valid with size=MSIZE4 and strobe=0. iresp.addr_ok and iresp.data_ok pulse with data 32'h2408_0001. dresp stays '0.
- Simultaneous request:
  - Stimulus: ireq (addr 32'h100) and dreq (write, addr 32'h8000_0010, strobe 4'hF, data 32'hDEAD_BEEF) assert in the same cycle.
  - Required response: dbus is served first with oreq.data=32'hDEAD_BEEF, then ibus. starve reads 1 during the dbus transaction and 0 after the ibus grant.
- Starvation:
  - Stimulus: dreq.valid held high continuously, ireq.valid held high, STARVE_LIMIT=4, single-cycle addr_ok+data_ok memory.
  - Required response: grant order is D,D,D,D,I,D,…
- Combined handshake:
  - Stimulus: memory asserts addr_ok and data_ok in the same cycle.
  - Required response: FSM goes ADDR→IDLE directly; the requester sees both pulses in the same cycle; the next grant comes 1 cycle later.
- Reset mid-DATA:
  - Stimulus: resetn=0 for 1 cycle while waiting on data_ok, then memory asserts data_ok=1.
  - Required response: state=IDLE; oreq, iresp and dresp are '0; the late data_ok is not forwarded to either requester.
- Requester drop while not selected:
  - Stimulus: ibus is in DATA while dreq.valid toggles 1→0→1.
  - Required response: oreq is unaffected, dresp stays '0, and dbus is granted after the ibus data_ok.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Bus types shared by the core, the arbiter and the memory side, plus the arbiter FSM encoding.
package cbus_arbiter_pkg;

    typedef logic [2:0] msize_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Shares one memory port between the instruction and data buses, one transaction at a time.
// Handshake: a request is accepted in the cycle oresp.addr_ok is high while oreq.valid is high; the response completes on the cycle data_ok is high.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  ibus_req_t            ireq,
    output ibus_resp_t           iresp,
    input  dbus_req_t            dreq,
    output dbus_resp_t           dresp,
    output dbus_req_t            oreq,
    input  dbus_resp_t           oresp,
    output arb_state_t           debug_state,
    output logic                 debug_sel,
    output logic [CNT_W-1:0]     debug_starve
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic             sel;
    dbus_req_t        req_q;
    logic [CNT_W-1:0] starve;

    logic       ibus_wins;
    dbus_resp_t fwd;

    // dbus normally wins a tie; ibus wins once it has lost LIMIT times in a row.
    assign ibus_wins = ireq.valid && (!dreq.valid || (starve >= LIMIT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            sel    <= 1'b0;
            req_q  <= '0;
            starve <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq.valid && !ibus_wins)
                        starve <= (starve >= LIMIT) ? LIMIT : starve + 1'b1;
                    else
                        starve <= '0;
                    if (ireq.valid || dreq.valid) begin
                        state <= ADDR;
                        if (ibus_wins) begin
                            sel          <= 1'b0;
                            req_q.valid  <= 1'b1;
                            req_q.addr   <= ireq.addr;
                            req_q.size   <= MSIZE4;
                            req_q.strobe <= 4'b0;
                            req_q.data   <= 32'b0;
                        end else begin
                            sel         <= 1'b1;
                            req_q       <= dreq;
                            req_q.valid <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (oresp.addr_ok)
                        state <= oresp.data_ok ? IDLE : DATA;
                end
                DATA: begin
                    if (oresp.data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory responses reach only the selected requester, and only in the phase that expects them.
    always_comb begin
        fwd = '0;
        case (state)
            ADDR: begin
                fwd.addr_ok = oresp.addr_ok;
                fwd.data_ok = oresp.addr_ok && oresp.data_ok;
                if (fwd.data_ok)
                    fwd.data = oresp.data;
            end
            DATA: begin
                fwd.data_ok = oresp.data_ok;
                fwd.data    = oresp.data;
            end
            default: fwd = '0;
        endcase
    end

    assign iresp = sel ? '0 : ibus_resp_t'(fwd);
    assign dresp = sel ? fwd : '0;
    assign oreq  = (state == ADDR) ? req_q : '0;

    assign debug_state  = state;
    assign debug_sel    = sel;
    assign debug_starve = starve;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 4;

    logic             clk;
    logic             resetn;
    ibus_req_t        ireq;
    ibus_resp_t       iresp;
    dbus_req_t        dreq;
    dbus_resp_t       dresp;
    dbus_req_t        oreq;
    dbus_resp_t       oresp;
    arb_state_t       debug_state;
    logic             debug_sel;
    logic [CNT_W-1:0] debug_starve;

    int checks;
    int errors;

    cbus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ireq         (ireq),
        .iresp        (iresp),
        .dreq         (dreq),
        .dresp        (dresp),
        .oreq         (oreq),
        .oresp        (oresp),
        .debug_state  (debug_state),
        .debug_sel    (debug_sel),
        .debug_starve (debug_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    dbus_req_t exp_req;
    dbus_req_t dreq_w;
    logic      exp_sel [6];

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        ireq   = '0;
        dreq   = '0;
        oresp  = '0;
        exp_sel = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset
        cyc(); cyc();
        resetn = 1'b1;
        #1;
        chk("reset_state", 80'(debug_state), 80'(IDLE));
        chk("reset_oreq", 80'(oreq), 80'(0));
        chk("reset_iresp", 80'(iresp), 80'(0));
        chk("reset_dresp", 80'(dresp), 80'(0));
        chk("reset_starve", 80'(debug_starve), 80'(0));

        // Single fetch
        cyc();
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
        #1;
        chk("fetch_idle_no_oreq", 80'(oreq.valid), 80'(0));
        cyc(); #1;
        exp_req = '{valid: 1'b1, addr: 32'hBFC0_0000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        chk("fetch_oreq", 80'(oreq), 80'(exp_req));
        cyc(); #1;
        chk("fetch_oreq_hold", 80'(oreq), 80'(exp_req));
        chk("fetch_no_addr_ok_yet", 80'(iresp), 80'(0));
        cyc();
        oresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        ireq.valid = 1'b0;
        #1;
        chk("fetch_iresp_addr_ok", 80'(iresp), 80'({1'b1, 1'b0, 32'h0}));
        chk("fetch_dresp_quiet_a", 80'(dresp), 80'(0));
        cyc();
        oresp = '0;
        #1;
        chk("fetch_data_state", 80'(debug_state), 80'(DATA));
        chk("fetch_data_no_oreq", 80'(oreq), 80'(0));
        cyc(); cyc();
        oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h2408_0001};
        #1;
        chk("fetch_iresp_data", 80'(iresp), 80'({1'b0, 1'b1, 32'h2408_0001}));
        chk("fetch_dresp_quiet_d", 80'(dresp), 80'(0));
        cyc();
        oresp = '0;
        #1;
        chk("fetch_back_idle", 80'(debug_state), 80'(IDLE));

        // Simultaneous request: dbus first, then ibus
        ireq   = '{valid: 1'b1, addr: 32'h0000_0100};
        dreq_w = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE4, strobe: 4'hF, data: 32'hDEAD_BEEF};
        dreq   = dreq_w;
        cyc(); #1;
        chk("simul_oreq_dbus", 80'(oreq), 80'(dreq_w));
        chk("simul_sel_dbus", 80'(debug_sel), 80'(1));
        chk("simul_starve_1", 80'(debug_starve), 80'(1));
        oresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        dreq.valid = 1'b0;
        #1;
        chk("simul_dresp_addr_ok", 80'(dresp), 80'({1'b1, 1'b0, 32'h0}));
        chk("simul_iresp_quiet", 80'(iresp), 80'(0));
        cyc();
        oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h1234_5678};
        #1;
        chk("simul_dresp_data", 80'(dresp), 80'({1'b0, 1'b1, 32'h1234_5678}));
        chk("simul_starve_hold", 80'(debug_starve), 80'(1));
        cyc();
        oresp = '0;
        #1;
        chk("simul_idle_turnaround", 80'(oreq.valid), 80'(0));
        cyc(); #1;
        exp_req = '{valid: 1'b1, addr: 32'h0000_0100, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        chk("simul_oreq_ibus", 80'(oreq), 80'(exp_req));
        chk("simul_starve_0", 80'(debug_starve), 80'(0));

        // Combined handshake on the ibus transaction
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCAFE_0001};
        ireq.valid = 1'b0;
        #1;
        chk("comb_iresp_both", 80'(iresp), 80'({1'b1, 1'b1, 32'hCAFE_0001}));
        cyc();
        oresp  = '0;
        dreq_w = '{valid: 1'b1, addr: 32'h0000_0044, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        dreq   = dreq_w;
        #1;
        chk("comb_direct_idle", 80'(debug_state), 80'(IDLE));
        cyc(); #1;
        chk("comb_next_grant", 80'(oreq), 80'(dreq_w));
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        dreq.valid = 1'b0;
        cyc();
        oresp = '0;

        // Starvation: both held, memory completes every ADDR cycle
        ireq   = '{valid: 1'b1, addr: 32'h0000_0500};
        dreq_w = '{valid: 1'b1, addr: 32'h8000_0600, size: MSIZE4, strobe: 4'h3, data: 32'h0000_0066};
        dreq   = dreq_w;
        oresp  = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            chk($sformatf("starve_sel_%0d", i), 80'(debug_sel), 80'(exp_sel[i]));
            chk($sformatf("starve_addr_%0d", i), 80'(oreq.addr),
                80'(exp_sel[i] ? 32'h8000_0600 : 32'h0000_0500));
            cyc();
        end
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        cyc(); #1;
        chk("starve_drain_idle", 80'(debug_state), 80'(IDLE));

        // Reset while waiting in DATA
        dreq = '{valid: 1'b1, addr: 32'h0000_0200, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        cyc();
        oresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        dreq.valid = 1'b0;
        cyc();
        oresp = '0;
        #1;
        chk("rst_mid_in_data", 80'(debug_state), 80'(DATA));
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h0000_0BAD};
        #1;
        chk("rst_mid_state", 80'(debug_state), 80'(IDLE));
        chk("rst_mid_oreq", 80'(oreq), 80'(0));
        chk("rst_mid_iresp", 80'(iresp), 80'(0));
        chk("rst_mid_dresp", 80'(dresp), 80'(0));
        cyc();
        oresp = '0;
        #1;
        chk("rst_mid_still_idle", 80'(debug_state), 80'(IDLE));

        // dbus toggles while ibus is in DATA
        ireq = '{valid: 1'b1, addr: 32'h0000_0300};
        cyc();
        oresp  = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        ireq.valid = 1'b0;
        dreq_w = '{valid: 1'b1, addr: 32'h0000_0400, size: MSIZE4, strobe: 4'hF, data: 32'h0000_0055};
        dreq   = dreq_w;
        #1;
        chk("drop_iresp_addr_ok", 80'(iresp), 80'({1'b1, 1'b0, 32'h0}));
        chk("drop_dresp_quiet_a", 80'(dresp), 80'(0));
        cyc();
        oresp = '0;
        dreq.valid = 1'b0;
        #1;
        chk("drop_oreq_quiet_0", 80'(oreq), 80'(0));
        chk("drop_dresp_quiet_0", 80'(dresp), 80'(0));
        cyc();
        dreq.valid = 1'b1;
        #1;
        chk("drop_still_data", 80'(debug_state), 80'(DATA));
        chk("drop_dresp_quiet_1", 80'(dresp), 80'(0));
        cyc();
        oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h0000_0077};
        #1;
        chk("drop_iresp_data", 80'(iresp), 80'({1'b0, 1'b1, 32'h0000_0077}));
        chk("drop_dresp_quiet_d", 80'(dresp), 80'(0));
        cyc();
        oresp = '0;
        cyc(); #1;
        chk("drop_dbus_granted", 80'(oreq), 80'(dreq_w));
        chk("drop_sel_dbus", 80'(debug_sel), 80'(1));
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        dreq.valid = 1'b0;
        cyc();
        oresp = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
